// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the handshaked ALU pipeline.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bits needed to express a shift amount in 0..width-1.
  function automatic int shamt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per step, WIDTH steps per multiply.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = shamt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      if (mplier_q[cnt_q]) acc_q <= acc_q + (mcand_q << cnt_q);
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // High during the final step, so the product is complete right after this edge.
  assign done_o    = step_i & (cnt_q == LAST_CNT);
  assign product_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU: one-cycle ops at full throughput, sequential multiply, registered result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int SW  = shamt_width(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic               out_valid_q, carry_q, zero_q, ovf_q;
  logic [WIDTH-1:0]   result_q;

  logic               slot_free, accept, accept_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   res_d;
  logic               carry_d, ovf_d;
  logic [SW-1:0]      shamt;

  assign slot_free  = ~out_valid_q | out_ready;
  assign in_ready   = (state_q == ST_IDLE) | ((state_q == ST_EXEC) & slot_free);
  assign accept     = in_valid & in_ready;
  assign accept_mul = accept & MUL_EN & (op == OP_MUL);
  assign shamt      = b_q[SW-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept_mul),
    .step_i    (state_q == ST_MUL),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op_q)
      OP_ADD: begin
        {carry_d, res_d} = {1'b0, a_q} + {1'b0, b_q};
        ovf_d = (a_q[MSB] == b_q[MSB]) & (res_d[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        {carry_d, res_d} = {1'b0, a_q} - {1'b0, b_q};
        ovf_d = (a_q[MSB] != b_q[MSB]) & (res_d[MSB] != a_q[MSB]);
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      // The spare bit beside the operand catches the last bit shifted out.
      OP_SHL: {carry_d, res_d} = {1'b0, a_q} << shamt;
      OP_SHR: {res_d, carry_d} = {a_q, 1'b0} >> shamt;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand and output registers are reset too, so a reset in the
    // middle of a multiply or a stall can never replay a stale beat.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      case (state_q)
        ST_IDLE: if (accept) state_q <= accept_mul ? ST_MUL : ST_EXEC;
        ST_EXEC: if (slot_free) begin
          result_q    <= res_d;
          carry_q     <= carry_d;
          zero_q      <= (res_d == '0);
          ovf_q       <= ovf_d;
          out_valid_q <= 1'b1;
          if (!accept)         state_q <= ST_IDLE;
          else if (accept_mul) state_q <= ST_MUL;
          else                 state_q <= ST_EXEC;
        end
        ST_MUL: if (mul_done) state_q <= ST_DONE;
        ST_DONE: if (slot_free) begin
          result_q    <= mul_product[WIDTH-1:0];
          carry_q     <= |mul_product[2*WIDTH-1:WIDTH];
          ovf_q       <= |mul_product[2*WIDTH-1:WIDTH];
          zero_q      <= (mul_product[WIDTH-1:0] == '0);
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == ST_MUL) | (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=4: directed beats push expectations, a monitor pops and compares.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         in_ready, out_valid, carry, zero, overflow, busy;
  logic [W-1:0] result;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_beats = 0;
  exp_t sb[$];

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic z, input logic v);
    return {r, c, z, v};
  endfunction

  // Holds in_valid until accepted, then pushes the expected response.
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input exp_t e, output int waits);
    op = o; a = x; b = y; in_valid = 1'b1; waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready && waits < 50);
    check("send_accept", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_beats++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got result %0h, no beat expected (t=%0t)", result, $time);
        end else begin
          e = sb.pop_front();
          check("beat_result",   32'(result),   32'(e.r));
          check("beat_carry",    32'(carry),    32'(e.c));
          check("beat_zero",     32'(zero),     32'(e.z));
          check("beat_overflow", 32'(overflow), 32'(e.v));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w, total, beats0;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_carry",     32'(carry),     32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    #10 rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // ADD wrap-around and single-cycle latency
    send(OP_ADD, 4'hF, 4'h1, mk(4'h0, 1'b1, 1'b1, 1'b0), w);
    check("add_not_yet_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("add_valid_k1", 32'(out_valid), 32'd1);

    // SUB borrow and signed overflow
    send(OP_SUB, 4'h3, 4'h5, mk(4'hE, 1'b1, 1'b0, 1'b0), w);
    send(OP_SUB, 4'h8, 4'h1, mk(4'h7, 1'b0, 1'b0, 1'b1), w);
    repeat (3) @(posedge clk);
    #1;

    // MUL 7*3 = 0x15: latency WIDTH+1, stalls the input meanwhile
    send(OP_MUL, 4'h7, 4'h3, mk(4'h5, 1'b1, 1'b0, 1'b1), w);
    check("mul_busy_0",     32'(busy),      32'd1);
    check("mul_in_ready_0", 32'(in_ready),  32'd0);
    check("mul_valid_0",    32'(out_valid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check("mul_busy",     32'(busy),      32'd1);
      check("mul_in_ready", 32'(in_ready),  32'd0);
      check("mul_valid",    32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    check("mul_valid_k5", 32'(out_valid), 32'd1);
    check("mul_busy_end", 32'(busy),      32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Output back-pressure: first beat held, second latched, both delivered in order
    out_ready = 1'b0;
    send(OP_ADD, 4'h2, 4'h3, mk(4'h5, 1'b0, 1'b0, 1'b0), w);
    send(OP_XOR, 4'hA, 4'h5, mk(4'hF, 1'b0, 1'b0, 1'b0), w);
    beats0 = n_beats;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid",    32'(out_valid), 32'd1);
      check("stall_result",   32'(result),    32'd5);
      check("stall_in_ready", 32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stall_beats", 32'(n_beats - beats0), 32'd2);
    check("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during the second multiply cycle discards the product
    send(OP_MUL, 4'h5, 4'h5, mk(4'h9, 1'b1, 1'b0, 1'b1), w);
    @(posedge clk); #1;
    #2;
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result",    32'(result),    32'd0);
    check("midrst_carry",     32'(carry),     32'd0);
    check("midrst_zero",      32'(zero),      32'd0);
    check("midrst_overflow",  32'(overflow),  32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    beats0 = n_beats;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_beat", 32'(n_beats - beats0), 32'd0);
    check("midrst_idle_valid", 32'(out_valid), 32'd0);

    // Full-throughput stream of shifts and ANDs
    beats0 = n_beats;
    total = 0;
    send(OP_SHL, 4'h9, 4'h1, mk(4'h2, 1'b1, 1'b0, 1'b0), w); total += w;
    send(OP_SHR, 4'h1, 4'h0, mk(4'h1, 1'b0, 1'b0, 1'b0), w); total += w;
    send(OP_AND, 4'hC, 4'hA, mk(4'h8, 1'b0, 1'b0, 1'b0), w); total += w;
    send(OP_SHL, 4'h3, 4'h6, mk(4'hC, 1'b0, 1'b0, 1'b0), w); total += w;
    send(OP_SHR, 4'h5, 4'h1, mk(4'h2, 1'b1, 1'b0, 1'b0), w); total += w;
    send(OP_AND, 4'h5, 4'hA, mk(4'h0, 1'b0, 1'b1, 1'b0), w); total += w;
    send(OP_SHL, 4'h2, 4'h3, mk(4'h0, 1'b1, 1'b1, 1'b0), w); total += w;
    send(OP_SHR, 4'hA, 4'h3, mk(4'h1, 1'b0, 1'b0, 1'b0), w); total += w;
    check("stream_accept_cycles", 32'(total), 32'd8);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("stream_beats", 32'(n_beats - beats0), 32'd8);

    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, handshaked successor to the fixed 4-bit registered ALU wrapper. Width is generic. Valid/ready flow control on input and output. Adds zero and overflow flags and a multi-cycle shift-add multiply op. Sits between an operand source and a result consumer; either side may stall.

Parameters:
WIDTH, 4, operand/result width in bits; must be at least 2.
MUL_EN, 1, 1 = MUL implemented; 0 = MUL completes single-cycle with result 0 and all flags 0 except zero=1.

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B; for shifts, the low clog2(WIDTH) bits are the shift amount
op  input  3  opcode
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
carry  output  1  carry / borrow / shifted-out / MUL high-half-nonzero
zero  output  1  result == 0
overflow  output  1  signed overflow
busy  output  1  multiply in progress (state MUL or DONE)

Behaviour:
- Reset (async, any state): state=IDLE; out_valid=0; result=0; carry=0; zero=0; overflow=0; busy=0; operand registers=0. in_ready=1 once out of reset.
- An input beat is accepted on an edge where in_valid & in_ready are both 1. An output beat is consumed on an edge where out_valid & out_ready are both 1.
- slot_free = ~out_valid | out_ready.
- in_ready = (state==IDLE) | (state==EXEC & slot_free). This is combinational from registered state and out_ready only; in_valid is not used.
- FSM states and transitions:
  - IDLE: on accept of a non-MUL op (or any op when MUL_EN=0), latch a, b, op and go to EXEC. On accept of MUL, latch operands, clear acc and cnt, and go to MUL.
  - EXEC: when slot_free, write the computed result and flags to the output register and set out_valid. Then go to IDLE, or stay in EXEC if a new non-MUL beat is accepted the same edge, or go to MUL if the new beat is MUL. This gives full throughput of 1 op/cycle. When not slot_free, hold.
  - MUL: one shift-add step per cycle. If multiplier bit cnt is 1, acc += multiplicand << cnt (acc is 2*WIDTH wide). cnt increments each step; after WIDTH steps go to DONE.
  - DONE: when slot_free, write acc[WIDTH-1:0], set carry=|acc[2W-1:W] and overflow=carry, set out_valid, then go to IDLE.
- Latency (out_ready=1):
  - Non-MUL op accepted at edge k: out_valid is high after edge k+1.
  - MUL accepted at edge k: out_valid is high after edge k+WIDTH+1.
  - in_ready is 0 throughout MUL and DONE.
- Output register holds result, flags and out_valid stable while out_valid & ~out_ready. out_valid drops on consume unless new data is written on the same edge.
- Opcodes:
  - 000 ADD: carry = carry-out; overflow = (a[msb]==b[msb]) & (r[msb]!=a[msb]).
  - 001 SUB: r=a-b mod 2^W; carry = borrow (a<b unsigned); overflow = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
  - 010 AND, 011 OR, 100 XOR: carry=0, overflow=0.
  - 101 SHL, 110 SHR (logical): carry = last bit shifted out, 0 when shift amount is 0; overflow=0.
  - 111 MUL: low half of the unsigned product.
- zero = (written result == 0) for every op.
- Reset mid-MUL or mid-stall discards all in-flight work; no stale beat is emitted afterwards.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD..OP_MUL;
  - FSM state encoding ST_IDLE, ST_EXEC, ST_MUL, ST_DONE;
  - function computing the shift-amount width clog2(WIDTH).
- Sub-module alu_mul_seq (WIDTH): holds acc, cnt and the multiplicand/multiplier registers. Ports: start, step enable, done, product. The top level keeps the FSM, the single-cycle datapath and the output register.

Test Plan (WIDTH=4):
1. ADD a=F b=1, out_ready=1 -> out_valid after edge k+1; result=0, carry=1, zero=1, overflow=0.
2. SUB a=3 b=5 -> result=E, carry=1, overflow=0. SUB a=8 b=1 -> result=7, carry=0, overflow=1.
3. MUL a=7 b=3 -> result=5, carry=1, overflow=1. out_valid exactly 5 edges after accept; in_ready=0 and busy=1 in between.
4. out_ready=0, back-to-back ADD 2+3 then XOR A^5 -> first beat (5) held stable, second beat latched, in_ready=0. Raise out_ready -> 5 then F delivered in order, no loss or duplication.
5. Assert rst_n=0 during MUL cycle 2 -> all outputs 0 immediately, in_ready=1 after release, no result emitted.
6. Stream 8 SHL/SHR/AND beats with in_valid=out_ready=1 -> one result per cycle. Check SHL 9<<1 = 2 with carry=1, and SHR 1>>0 = 1 with carry=0.
